quan_multi_lane: RTL

- Parametrised successor of the single-lane uint8 requantizer.
- Converts LANES 32-bit MAC+bias results per beat to OUT_W-bit quantized outputs using per-output-channel scale (m0) and shift held in an internal table.
- Supports signed/unsigned output modes, optional fused ReLU, and valid/ready back-pressure.
- Sits between the accumulator readout (ru_get path) and the output-feature-map writer.

---
 rtl/quan_multi_lane.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/quan_multi_lane.sv
// Requantizes LANES signed 32-bit accumulator results per beat to OUT_W-bit outputs using per-channel m0/shift.
// Fixed 5-cycle latency at 1 beat/cycle; a single global enable freezes every stage while the output is stalled.
module quan_multi_lane #(
   parameter int LANES = 4,
   parameter int DEPTH = 64,
   parameter int OUT_W = 8,
   parameter int CH_W  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   cfg_we,
   input  logic [CH_W-1:0]        cfg_addr,
   input  logic [31:0]            cfg_m0,
   input  logic [4:0]             cfg_shift,
   input  logic [15:0]            z_of_weight,
   input  logic [15:0]            z3,
   input  logic                   signed_out,
   input  logic                   relu_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*32-1:0]    in_acc,
   input  logic [LANES*32-1:0]    in_act_sum,
   input  logic [CH_W-1:0]        in_ch,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_q,
   output logic                   out_last
);

   typedef struct packed {
      logic [15:0] z3;
      logic        sgn;
      logic        relu;
      logic        last;
   } meta_t;

   localparam logic signed [33:0] U_HI = (34'sd1 <<< OUT_W) - 34'sd1;
   localparam logic signed [33:0] S_LO = -(34'sd1 <<< (OUT_W - 1));
   localparam logic signed [33:0] S_HI = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;

   logic signed [31:0] tbl_m0_q [DEPTH], tbl_m0_d [DEPTH];
   logic [4:0]         tbl_sh_q [DEPTH], tbl_sh_d [DEPTH];

   logic [4:0]         vld_q, vld_d;
   meta_t              meta_q [4], meta_d [4];
   logic signed [31:0] s1_x_q [LANES], s1_x_d [LANES];
   logic signed [31:0] s1_m0_q [LANES], s1_m0_d [LANES];
   logic [4:0]         s1_sh_q [LANES], s1_sh_d [LANES];
   logic signed [31:0] s2_y_q [LANES], s2_y_d [LANES];
   logic [4:0]         s2_sh_q [LANES], s2_sh_d [LANES];
   logic signed [31:0] s3_r_q [LANES], s3_r_d [LANES];
   logic signed [33:0] s4_t_q [LANES], s4_t_d [LANES];
   logic [LANES*OUT_W-1:0] out_q_q, out_q_d;
   logic               out_last_q, out_last_d;
   logic               en;

   function automatic logic signed [31:0] srdhm(input logic signed [31:0] a, input logic signed [31:0] b);
      logic signed [63:0] p, s;
      if (a == 32'sh8000_0000 && b == 32'sh8000_0000) return 32'sh7fff_ffff;
      p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      s = p + (p[63] ? -64'sd1073741823 : 64'sd1073741824);
      // Bias negatives so the arithmetic shift truncates toward zero
      if (s[63]) s = s + 64'sd2147483647;
      return 32'(s >>> 31);
   endfunction

   function automatic logic signed [31:0] rdbpot(input logic signed [31:0] y, input logic [4:0] sh);
      logic [31:0] mask, rem, thr;
      mask = (32'd1 << sh) - 32'd1;
      rem  = y & mask;
      thr  = (mask >> 1) + {31'd0, y[31]};
      return (y >>> sh) + ((rem > thr) ? 32'sd1 : 32'sd0);
   endfunction

   function automatic logic [OUT_W-1:0] clamp(input logic signed [33:0] t, input logic [15:0] zp,
                                              input logic sgn, input logic relu);
      logic signed [33:0] lo, hi, z, v;
      z  = {{18{zp[15]}}, zp};
      lo = sgn ? S_LO : 34'sd0;
      hi = sgn ? S_HI : U_HI;
      if (relu && z > lo) lo = z;
      v = (t < lo) ? lo : t;
      if (v > hi) v = hi;
      return OUT_W'(v);
   endfunction

   assign en        = !vld_q[4] || out_ready;
   assign in_ready  = en;
   assign out_valid = vld_q[4];
   assign out_q     = out_q_q;
   assign out_last  = out_last_q;

   always_comb begin
      tbl_m0_d   = tbl_m0_q;
      tbl_sh_d   = tbl_sh_q;
      vld_d      = vld_q;
      meta_d     = meta_q;
      s1_x_d     = s1_x_q;
      s1_m0_d    = s1_m0_q;
      s1_sh_d    = s1_sh_q;
      s2_y_d     = s2_y_q;
      s2_sh_d    = s2_sh_q;
      s3_r_d     = s3_r_q;
      s4_t_d     = s4_t_q;
      out_q_d    = out_q_q;
      out_last_d = out_last_q;
      // Table writes land regardless of stalls; same-cycle reads below see the old entry
      if (cfg_we) begin
         tbl_m0_d[cfg_addr] = cfg_m0;
         tbl_sh_d[cfg_addr] = cfg_shift;
      end
      if (en) begin
         vld_d      = {vld_q[3:0], in_valid};
         meta_d[0]  = '{z3: z3, sgn: signed_out, relu: relu_en, last: in_last};
         for (int i = 1; i < 4; i++) meta_d[i] = meta_q[i-1];
         out_last_d = meta_q[3].last;
         for (int l = 0; l < LANES; l++) begin
            s1_x_d[l]  = in_acc[32*l +: 32] - in_act_sum[32*l +: 32] * {{16{z_of_weight[15]}}, z_of_weight};
            s1_m0_d[l] = tbl_m0_q[in_ch + CH_W'(l)];
            s1_sh_d[l] = tbl_sh_q[in_ch + CH_W'(l)];
            s2_y_d[l]  = srdhm(s1_x_q[l], s1_m0_q[l]);
            s2_sh_d[l] = s1_sh_q[l];
            s3_r_d[l]  = rdbpot(s2_y_q[l], s2_sh_q[l]);
            s4_t_d[l]  = {{2{s3_r_q[l][31]}}, s3_r_q[l]} + {{18{meta_q[2].z3[15]}}, meta_q[2].z3};
            out_q_d[OUT_W*l +: OUT_W] = clamp(s4_t_q[l], meta_q[3].z3, meta_q[3].sgn, meta_q[3].relu);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tbl_m0_q   <= '{default: '0};
         tbl_sh_q   <= '{default: '0};
         vld_q      <= '0;
         meta_q     <= '{default: '0};
         s1_x_q     <= '{default: '0};
         s1_m0_q    <= '{default: '0};
         s1_sh_q    <= '{default: '0};
         s2_y_q     <= '{default: '0};
         s2_sh_q    <= '{default: '0};
         s3_r_q     <= '{default: '0};
         s4_t_q     <= '{default: '0};
         out_q_q    <= '0;
         out_last_q <= 1'b0;
      end else begin
         tbl_m0_q   <= tbl_m0_d;
         tbl_sh_q   <= tbl_sh_d;
         vld_q      <= vld_d;
         meta_q     <= meta_d;
         s1_x_q     <= s1_x_d;
         s1_m0_q    <= s1_m0_d;
         s1_sh_q    <= s1_sh_d;
         s2_y_q     <= s2_y_d;
         s2_sh_q    <= s2_sh_d;
         s3_r_q     <= s3_r_d;
         s4_t_q     <= s4_t_d;
         out_q_q    <= out_q_d;
         out_last_q <= out_last_d;
      end
   end

endmodule
